// File: rtl/lcd_frame_driver.sv
// HD44780 16x2 driver in 8-bit mode: power-up wait, four init commands, then endless two-line refresh.
// Outputs decode registered state directly; each frame shows one snapshot of lcd_data_in taken at its ADDR1 step.
module lcd_frame_driver #(
    parameter int POWERUP_CYCLES = 200000,
    parameter int STEP_CYCLES    = 500,
    parameter int EN_CYCLES      = 50,
    parameter int CLEAR_CYCLES   = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] lcd_data_in,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_db,
    output logic         init_done,
    output logic         frame_done
);

    localparam int MAX_STEP = (STEP_CYCLES > CLEAR_CYCLES) ? STEP_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYC  = (MAX_STEP > POWERUP_CYCLES) ? MAX_STEP : POWERUP_CYCLES;
    localparam int CW       = $clog2(MAX_CYC + 1);

    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_ADDR1   = 3'd2;
    localparam logic [2:0] S_CHAR1   = 3'd3;
    localparam logic [2:0] S_ADDR2   = 3'd4;
    localparam logic [2:0] S_CHAR2   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [255:0]  snap;
    logic [CW-1:0] last_cnt;
    logic          step_end;
    logic [127:0]  line;
    logic [7:0]    raw_chr;

    always_comb begin
        last_cnt = CW'(STEP_CYCLES - 1);
        if (state == S_POWERUP)
            last_cnt = CW'(POWERUP_CYCLES - 1);
        else if (state == S_INIT && idx == 4'd3)
            last_cnt = CW'(CLEAR_CYCLES - 1);
    end

    assign step_end = (cnt == last_cnt);

    // idx doubles as init command index and column; it wraps 15->0 at each line end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_POWERUP;
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
        end else begin
            if (state == S_ADDR1 && cnt == '0)
                snap <= lcd_data_in;
            if (step_end) begin
                cnt <= '0;
                case (state)
                    S_POWERUP: begin
                        state <= S_INIT;
                        idx   <= '0;
                    end
                    S_INIT: begin
                        if (idx == 4'd3) begin
                            state <= S_ADDR1;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    S_ADDR1: state <= S_CHAR1;
                    S_CHAR1: begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd15)
                            state <= S_ADDR2;
                    end
                    S_ADDR2: state <= S_CHAR2;
                    S_CHAR2: begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd15)
                            state <= S_ADDR1;
                    end
                    default: state <= S_POWERUP;
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign line    = (state == S_CHAR1) ? snap[255:128] : snap[127:0];
    assign raw_chr = line[{~idx, 3'b000} +: 8];

    always_comb begin
        lcd_rs = 1'b0;
        lcd_db = 8'h00;
        case (state)
            S_INIT: begin
                case (idx[1:0])
                    2'd0:    lcd_db = 8'h38;
                    2'd1:    lcd_db = 8'h0C;
                    2'd2:    lcd_db = 8'h06;
                    default: lcd_db = 8'h01;
                endcase
            end
            S_ADDR1: lcd_db = 8'h80;
            S_ADDR2: lcd_db = 8'hC0;
            S_CHAR1, S_CHAR2: begin
                lcd_rs = 1'b1;
                // non-printable bytes show as blanks so cleared memory reads as an empty screen
                lcd_db = (raw_chr >= 8'h20 && raw_chr <= 8'h7E) ? raw_chr : 8'h20;
            end
            default: ;
        endcase
    end

    assign lcd_en     = (state != S_POWERUP) && (cnt != '0) && (cnt <= CW'(EN_CYCLES));
    assign lcd_rw     = 1'b0;
    assign init_done  = (state == S_ADDR1) || (state == S_CHAR1) ||
                        (state == S_ADDR2) || (state == S_CHAR2);
    assign frame_done = (state == S_CHAR2) && (idx == 4'd15) && step_end;

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Random-data bench for lcd_frame_driver against a cycle-number-based reference model.
module tb_lcd_frame_driver;

    localparam int PU    = 20;
    localparam int STEP  = 8;
    localparam int EN    = 2;
    localparam int CLEAR = 16;
    localparam int INIT_LEN = 3 * STEP + CLEAR;
    localparam int FRAME    = 34 * STEP;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] data = '0;
    logic         lcd_en, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0]   lcd_db;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int scen  = 0;
    int last_fd = -1;
    int fd_count = 0;
    logic [255:0] msnap = '0;
    logic in_char1_en = 1'b0;
    logic [7:0] init_cmds [3] = '{8'h38, 8'h0C, 8'h06};

    lcd_frame_driver #(
        .POWERUP_CYCLES(PU), .STEP_CYCLES(STEP), .EN_CYCLES(EN), .CLEAR_CYCLES(CLEAR)
    ) dut (
        .clk(clk), .rst(rst), .lcd_data_in(data),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] shown(input logic [255:0] s, input int n);
        logic [7:0] b;
        b = s[8*(31-n) +: 8];
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
    endfunction

    // Expected outputs from the cycle number since reset release: {en, rs, rw, db, init_done, frame_done}
    task automatic model(output logic [12:0] e);
        int u, f, s, k;
        logic [7:0] db;
        logic en, rs, idn, fd;
        db = 8'h00; en = 1'b0; rs = 1'b0; idn = 1'b0; fd = 1'b0; k = 0;
        in_char1_en = 1'b0;
        if (t >= PU) begin
            u = t - PU;
            if (u < 3 * STEP) begin
                s = u / STEP;
                k = u % STEP;
                db = init_cmds[s];
            end else if (u < INIT_LEN) begin
                k = u - 3 * STEP;
                db = 8'h01;
            end else begin
                f = u - INIT_LEN;
                s = (f / STEP) % 34;
                k = f % STEP;
                idn = 1'b1;
                if (s == 0 && k == 0) msnap = data;
                if (s == 0) db = 8'h80;
                else if (s == 17) db = 8'hC0;
                else begin
                    rs = 1'b1;
                    db = shown(msnap, (s < 17) ? s - 1 : s - 2);
                end
                fd = (s == 33) && (k == STEP - 1);
                in_char1_en = (s >= 1) && (s <= 16) && (k == 1);
            end
            en = (k >= 1) && (k <= EN);
        end
        e = {en, rs, 1'b0, db, idn, fd};
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 32; i++) begin
            case ($urandom_range(0, 3))
                0: d[8*i +: 8] = 8'($urandom_range(0, 255));
                1: d[8*i +: 8] = 8'($urandom_range(8'h1E, 8'h21));
                2: d[8*i +: 8] = 8'($urandom_range(8'h7D, 8'h80));
                default: d[8*i +: 8] = 8'($urandom_range(8'h41, 8'h5A));
            endcase
        end
        return d;
    endfunction

    function automatic logic [255:0] filter_data();
        logic [255:0] d;
        d = '0;
        d[255:248] = 8'h0A;
        d[247:240] = 8'hFF;
        d[239:232] = 8'h7E;
        d[231:224] = 8'h7F;
        d[223:216] = 8'h1F;
        d[215:208] = 8'h20;
        d[127:120] = 8'h41;
        return d;
    endfunction

    task automatic drive_stim();
        if (scen == 0) begin
            if (t == 100) data = filter_data();
            else if (t >= 604 && $urandom_range(0, 29) == 0) data = rand_data();
        end else if ($urandom_range(0, 19) == 0) begin
            data = rand_data();
        end
    endtask

    task automatic check_now();
        logic [12:0] e;
        model(e);
        chk("outputs", {lcd_en, lcd_rs, lcd_rw, lcd_db, init_done, frame_done}, e);
        if (frame_done) begin
            if (last_fd >= 0) chk("fd_gap", t - last_fd, FRAME);
            last_fd = t;
            fd_count++;
        end
        if (scen == 0) begin
            case (t)
                19:  chk("pu_db", lcd_db, 8'h00);
                20:  chk("en_k0", lcd_en, 1'b0);
                21:  chk("en_k1", lcd_en, 1'b1);
                22:  chk("en_k2", lcd_en, 1'b1);
                23:  chk("en_k3", lcd_en, 1'b0);
                45:  chk("clr_db", lcd_db, 8'h01);
                59:  chk("init_lo", init_done, 1'b0);
                60:  chk("addr1", {init_done, lcd_rs, lcd_db}, {1'b1, 1'b0, 8'h80});
                68:  chk("h_char", {lcd_rs, lcd_db}, {1'b1, 8'h48});
                196: chk("addr2", {lcd_rs, lcd_db}, {1'b0, 8'hC0});
                204: chk("r_char", lcd_db, 8'h52);
                331: chk("fd1", frame_done, 1'b1);
                332: chk("frame2", lcd_db, 8'h80);
                340: chk("filt_0a", lcd_db, 8'h20);
                348: chk("filt_ff", lcd_db, 8'h20);
                356: chk("filt_7e", lcd_db, 8'h7E);
                364: chk("filt_7f", lcd_db, 8'h20);
                372: chk("filt_1f", lcd_db, 8'h20);
                380: chk("filt_20", lcd_db, 8'h20);
                476: chk("l2_col0", lcd_db, 8'h41);
                default: ;
            endcase
        end else if (t == 0) begin
            chk("rst_out", {lcd_en, lcd_rs, lcd_db, init_done, frame_done}, 12'h000);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        t++;
        drive_stim();
        @(negedge clk);
        check_now();
    endtask

    initial begin
        logic found;
        data = {"HELLO WORLD     ", "RV32I CPU       "};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        @(negedge clk);
        check_now();
        while (t < INIT_LEN + PU + 3 * FRAME + 10) step_cycle();
        chk("fd_count", fd_count, 3);

        // reset while lcd_en is high inside a CHAR1 step
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step_cycle();
            found = in_char1_en && lcd_en;
        end
        chk("find_char1", found, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        scen = 1;
        t = 0;
        last_fd = -1;
        fd_count = 0;
        @(negedge clk);
        check_now();
        while (t < INIT_LEN + PU + 2 * FRAME + 4) step_cycle();
        chk("fd_count2", fd_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
